// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter driving a universal shift register's serial input.
// Shifts WIDTH bits MSB- or LSB-first at one bit per DIV clocks, with per-bit strobe and mode code.
module serial_frame_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_DIR,
  input  logic             TX_VALID,
  output logic             TX_READY,
  input  logic             ABORT,
  output logic             S_OUT,
  output logic             SHIFT_EN,
  output logic [1:0]       CTRL_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_TO_MSB  = 2'b01;
  localparam logic [1:0] MODE_TO_LSB  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             dir, dir_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;

  // State and datapath registers
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= IDLE;
      shreg   <= '0;
      dir     <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      dir     <= dir_nxt;
      bit_cnt <= bit_cnt_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end

  // Next-state, datapath update and output decode
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    dir_nxt     = dir;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    TX_READY    = 1'b0;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    SHIFT_EN    = 1'b0;
    CTRL_OUT    = MODE_HOLD;
    S_OUT       = 1'b0;

    case (state)
      IDLE: begin
        TX_READY = 1'b1;
        if (TX_VALID) begin
          shreg_nxt   = TX_DATA;
          dir_nxt     = TX_DIR;
          bit_cnt_nxt = '0;
          div_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        BUSY     = 1'b1;
        CTRL_OUT = dir ? MODE_TO_LSB : MODE_TO_MSB;
        S_OUT    = dir ? shreg[0] : shreg[WIDTH-1];
        // Abort takes precedence over a strobe falling in the same cycle
        if (ABORT) begin
          shreg_nxt   = '0;
          bit_cnt_nxt = '0;
          div_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else if (div_cnt == DIV_LAST) begin
          SHIFT_EN    = 1'b1;
          shreg_nxt   = dir ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
          div_cnt_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = FIN;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized self-checking bench for serial_frame_tx (DIV=4 and DIV=1 instances),
// with cycle-accurate timing expectations and a behavioural receiving shift register.
module tb_serial_frame_tx;

  localparam int unsigned W = 8;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic [W-1:0] tx_data;
  logic         tx_dir;
  logic         tx_valid;
  logic         abort;
  logic         sel;

  logic         ready_a, s_out_a, shift_en_a, busy_a, done_a;
  logic [1:0]   ctrl_a;
  logic         ready_b, s_out_b, shift_en_b, busy_b, done_b;
  logic [1:0]   ctrl_b;
  logic         valid_a, valid_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLOCK = ~CLOCK;

  assign valid_a = tx_valid & ~sel;
  assign valid_b = tx_valid & sel;

  serial_frame_tx #(.WIDTH(W), .DIV(4)) dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .TX_DATA(tx_data), .TX_DIR(tx_dir),
    .TX_VALID(valid_a), .TX_READY(ready_a), .ABORT(abort), .S_OUT(s_out_a),
    .SHIFT_EN(shift_en_a), .CTRL_OUT(ctrl_a), .BUSY(busy_a), .DONE(done_a)
  );

  serial_frame_tx #(.WIDTH(W), .DIV(1)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .TX_DATA(tx_data), .TX_DIR(tx_dir),
    .TX_VALID(valid_b), .TX_READY(ready_b), .ABORT(abort), .S_OUT(s_out_b),
    .SHIFT_EN(shift_en_b), .CTRL_OUT(ctrl_b), .BUSY(busy_b), .DONE(done_b)
  );

  // Observed vector: {ready, busy, done, shift_en, ctrl[1:0], s_out}
  logic [6:0] obs;
  assign obs = sel ? {ready_b, busy_b, done_b, shift_en_b, ctrl_b, s_out_b}
                   : {ready_a, busy_a, done_a, shift_en_a, ctrl_a, s_out_a};

  localparam logic [6:0] V_IDLE = 7'b1000000;
  localparam logic [6:0] V_FIN  = 7'b0010000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame. kill_c: cycle (relative to handshake edge) at which ABORT or RESET is driven
  // (0 = ABORT during the handshake cycle, <0 = none). hold keeps TX_VALID high with the next word.
  task automatic do_frame(input bit sel_i, input logic [W-1:0] d, input bit dir_i,
                          input int kill_c, input bit kill_rst,
                          input bit hold, input logic [W-1:0] nd, input bit ndir);
    int div;
    int total;
    int n;
    bit killed;
    bit stop;
    logic [W-1:0] rx;
    logic [6:0] exp;
    int k;
    logic b;

    div    = sel_i ? 1 : 4;
    total  = W * div;
    killed = (kill_c >= 1) && (kill_c <= total);
    rx     = W'($urandom);
    stop   = 1'b0;

    sel      = sel_i;
    tx_data  = d;
    tx_dir   = dir_i;
    tx_valid = 1'b1;
    abort    = (kill_c == 0) && !kill_rst;
    #1;
    n = 0;
    while (!obs[6] && n < 100) begin
      @(negedge CLOCK);
      #1;
      n++;
    end
    check("ready_wait", 32'(obs[6]), 32'd1);
    @(posedge CLOCK);

    for (int c = 1; c <= total + 2 && !stop; c++) begin
      @(negedge CLOCK);
      if (c == 1) begin
        tx_valid = hold;
        if (hold) begin
          tx_data = nd;
          tx_dir  = ndir;
        end else begin
          tx_data = W'($urandom);
          tx_dir  = 1'($urandom);
        end
      end
      abort = !kill_rst && (c == kill_c);
      RESET = kill_rst && (c == kill_c);
      #1;

      if (killed && c == kill_c + 1) begin
        exp  = V_IDLE;
        stop = 1'b1;
      end else if (c <= total) begin
        k   = (c - 1) / div;
        b   = dir_i ? d[k] : d[W-1-k];
        exp = {1'b0, 1'b1, 1'b0,
               (c % div == 0) && !(killed && !kill_rst && c == kill_c),
               (dir_i ? 2'b11 : 2'b01), b};
      end else if (c == total + 1) begin
        exp = V_FIN;
      end else begin
        exp = V_IDLE;
      end
      check($sformatf("cyc%0d_d%02h_dir%0d_div%0d", c, d, dir_i, div), 32'(obs), 32'(exp));

      // Behavioural universal shift register on the receiving end
      if (obs[3]) begin
        if (obs[2:1] == 2'b01)      rx = {rx[W-2:0], obs[0]};
        else if (obs[2:1] == 2'b11) rx = {obs[0], rx[W-1:1]};
      end
      if (!killed && c == total + 1)
        check($sformatf("rx_word_d%02h_dir%0d", d, dir_i), 32'(rx), 32'(d));
    end
    abort = 1'b0;
    RESET = 1'b0;
  endtask

  initial begin
    RESET    = 1'b1;
    tx_data  = '0;
    tx_dir   = 1'b0;
    tx_valid = 1'b0;
    abort    = 1'b0;
    sel      = 1'b0;
    @(posedge CLOCK);
    @(posedge CLOCK);
    @(negedge CLOCK);
    #1;
    check("reset_a", 32'(obs), 32'(V_IDLE));
    sel = 1'b1;
    #1;
    check("reset_b", 32'(obs), 32'(V_IDLE));
    RESET = 1'b0;
    @(negedge CLOCK);

    // Directed cases
    do_frame(1'b0, 8'hC1, 1'b0, -1, 1'b0, 1'b0, '0, 1'b0);
    do_frame(1'b0, 8'hC1, 1'b1, -1, 1'b0, 1'b0, '0, 1'b0);
    do_frame(1'b0, 8'h5A, 1'b0, -1, 1'b0, 1'b1, 8'h0F, 1'b1);
    do_frame(1'b0, 8'h0F, 1'b1, -1, 1'b0, 1'b0, '0, 1'b0);
    do_frame(1'b0, 8'hA7, 1'b0, 12, 1'b0, 1'b0, '0, 1'b0);
    do_frame(1'b0, 8'h3C, 1'b1, 33, 1'b0, 1'b0, '0, 1'b0);
    do_frame(1'b0, 8'h96, 1'b0, 0,  1'b0, 1'b0, '0, 1'b0);
    do_frame(1'b0, 8'hE4, 1'b1, 10, 1'b1, 1'b0, '0, 1'b0);
    do_frame(1'b0, 8'h2B, 1'b0, -1, 1'b0, 1'b0, '0, 1'b0);
    do_frame(1'b1, 8'hFF, 1'b0, -1, 1'b0, 1'b0, '0, 1'b0);
    do_frame(1'b1, 8'h81, 1'b1, 4,  1'b0, 1'b0, '0, 1'b0);
    do_frame(1'b1, 8'h6D, 1'b1, -1, 1'b0, 1'b0, '0, 1'b0);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d;
      bit s;
      bit dr;
      int kc;
      bit kr;
      s  = 1'($urandom);
      d  = W'($urandom);
      dr = 1'($urandom);
      kc = -1;
      kr = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        kc = int'($urandom_range(0, s ? W + 1 : 4 * W + 1));
        kr = (kc > 0) && ($urandom_range(0, 2) == 0);
      end
      do_frame(s, d, dr, kc, kr, 1'b0, '0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial transmitter that feeds the serial input of the universal shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per DIV clocks.
- Emits a per-bit shift strobe and the 2-bit mode code the receiving register needs: 01 shift toward MSB, 11 shift toward LSB, 00 hold.
- After WIDTH strobes the receiving register holds exactly the transmitted word.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- DIV, 4, clock cycles per serial bit (>= 1).

Ports:
- CLOCK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- TX_DATA  input  WIDTH  word to transmit; sampled on handshake.
- TX_DIR  input  1  sampled on handshake; 0 = MSB first (receiver code 01), 1 = LSB first (receiver code 11).
- TX_VALID  input  1  request to transmit TX_DATA.
- TX_READY  output  1  high only in IDLE; transfer occurs when TX_VALID and TX_READY are both high at a rising edge.
- ABORT  input  1  cancels a frame in progress.
- S_OUT  output  1  serial data bit to the receiver's serial input.
- SHIFT_EN  output  1  one-cycle strobe; receiver shifts on this edge.
- CTRL_OUT  output  2  mode code for the receiver.
- BUSY  output  1  high in SHIFT.
- DONE  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset values (registered, effective the cycle after RESET is sampled high):
  - State IDLE; S_OUT=0, SHIFT_EN=0, CTRL_OUT=00, BUSY=0, DONE=0, TX_READY=1.
  - Shift register and counters cleared.
- RESET has priority over all inputs in every state.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - TX_READY=1.
  - On handshake at edge N: latch TX_DATA into shreg, latch TX_DIR, bit_cnt=0, div_cnt=0, go to SHIFT.
  - TX_VALID while not ready is ignored; no buffering.
- SHIFT:
  - BUSY=1, TX_READY=0.
  - CTRL_OUT = 01 if the latched dir is 0, 11 if it is 1.
  - S_OUT = shreg[WIDTH-1] (dir 0) or shreg[0] (dir 1); it is combinational from the registered shreg and stable for the full bit period.
  - div_cnt counts 0..DIV-1.
  - SHIFT_EN=1 exactly when div_cnt==DIV-1. On that edge: shreg shifts by one (left for dir 0, right for dir 1, zero fill), bit_cnt increments, div_cnt wraps to 0.
  - When the strobe fires with bit_cnt==WIDTH-1, go to FIN.
  - DIV=1: SHIFT_EN is high on every SHIFT cycle.
- FIN:
  - Lasts one cycle: DONE=1, CTRL_OUT=00, S_OUT=0, BUSY=0, TX_READY=0.
  - Then go to IDLE.
- Timing, with handshake at edge N:
  - SHIFT cycles run N+1 .. N+WIDTH*DIV.
  - Strobes occur in cycles N+k*DIV, k=1..WIDTH.
  - DONE is high in cycle N+WIDTH*DIV+1.
  - TX_READY returns high in cycle N+WIDTH*DIV+2.
- ABORT:
  - Sampled high in SHIFT: go to IDLE next cycle, with no SHIFT_EN in that cycle even if div_cnt==DIV-1 (ABORT wins).
  - No DONE; CTRL_OUT=00 and S_OUT=0 from the next cycle.
  - Ignored in IDLE and FIN.
- Changing TX_DATA or TX_DIR during SHIFT has no effect on the frame in progress.
- Counter widths: bit_cnt spans 0..WIDTH-1, div_cnt spans 0..DIV-1; both use clog2 width with a minimum of 1 bit.

Test Plan:
- WIDTH=8, DIV=4, TX_DATA=0xC1, TX_DIR=0, handshake at N -> S_OUT per bit period 1,1,0,0,0,0,0,1; CTRL_OUT=01; SHIFT_EN at N+4,N+8,...,N+32; DONE at N+33; TX_READY high at N+34.
- Same word, TX_DIR=1 -> S_OUT 1,0,0,0,0,0,1,1; CTRL_OUT=11. A behavioural universal shift register model driven by S_OUT, CTRL_OUT and SHIFT_EN (as enable) holds 0xC1 after DONE for both directions.
- TX_VALID held high across frames, data 0x5A then 0x0F -> second handshake exactly at N+34; TX_READY is low N+1..N+33; 0x0F is not taken early.
- ABORT high in the cycle of the 3rd strobe (N+12) -> no strobe at N+12, IDLE at N+13 with CTRL_OUT=00, no DONE pulse, TX_READY=1.
- RESET asserted at N+10 mid-frame -> next cycle all outputs at reset values; the following handshake transmits correctly from bit 0.
- DIV=1, WIDTH=8, 0xFF -> SHIFT_EN high N+1..N+8; S_OUT=1 throughout; DONE at N+9.
